// File: rtl/yutorina_bus_master_pkg.sv
// Shared definitions for the yutorina bus: FSM encodings, strobe polarities and bus widths.
// Slaves import the same width constants so address and data buses always agree.
package yutorina_bus_master_pkg;

    localparam int WORD_ADDR_W = 30;
    localparam int WORD_DATA_W = 32;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_REQ    = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    localparam logic READ  = 1'b1;
    localparam logic WRITE = 1'b0;

    // Active-low bus control levels.
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    function automatic logic asserted_n(input logic sig_n);
        return sig_n == ENABLE_;
    endfunction

endpackage

// File: rtl/yutorina_bus_watchdog.sv
// Access timeout counter for the bus master; only built when YUTORINA_BUS_TIMEOUT_EN is defined.
// Clears on i_clr, counts while i_en, saturates at TIMEOUT-1 and flags o_expired there.
`ifdef YUTORINA_BUS_TIMEOUT_EN
module yutorina_bus_watchdog #(
    parameter int TIMEOUT = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != LAST)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_expired = (r_cnt == LAST);

endmodule
`endif

// File: rtl/yutorina_bus_master.sv
// Core-side bus initiator: request -> grant -> one-cycle address strobe -> wait for ready -> done pulse.
// Optional access timeout under YUTORINA_BUS_TIMEOUT_EN aborts a hung slave with done+err.
module yutorina_bus_master
    import yutorina_bus_master_pkg::*;
#(
    parameter int ADDR_W  = WORD_ADDR_W,
    parameter int DATA_W  = WORD_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req,
    input  logic              i_rw,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic              o_bus_req_,
    input  logic              i_bus_grnt_,
    output logic              o_bus_as_,
    output logic              o_bus_rw,
    output logic [ADDR_W-1:0] o_bus_addr,
    output logic [DATA_W-1:0] o_bus_wr_data,
    input  logic [DATA_W-1:0] i_bus_rd_data,
    input  logic              i_bus_rdy_
);

    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("TIMEOUT must be at least 2");
    end

    logic [1:0]        r_state;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_done;
    logic              r_err;
    logic              r_bus_req_;
    logic              r_bus_as_;
    logic              r_bus_rw;
    logic [ADDR_W-1:0] r_bus_addr;
    logic [DATA_W-1:0] r_bus_wr_data;

    logic w_grant;
    logic w_ready;
    logic w_expired;

    assign w_grant = asserted_n(i_bus_grnt_);
    assign w_ready = asserted_n(i_bus_rdy_);

`ifdef YUTORINA_BUS_TIMEOUT_EN
    logic w_wdt_clr;
    logic w_wdt_en;

    assign w_wdt_clr = (r_state == ST_REQ) && w_grant;
    assign w_wdt_en  = (r_state == ST_ACCESS) && !w_ready;

    yutorina_bus_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clr     (w_wdt_clr),
        .i_en      (w_wdt_en),
        .o_expired (w_expired)
    );
`else
    assign w_expired = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= ST_IDLE;
            r_rd_data     <= '0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            r_bus_req_    <= DISABLE_;
            r_bus_as_     <= DISABLE_;
            r_bus_rw      <= READ;
            r_bus_addr    <= '0;
            r_bus_wr_data <= '0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_req) begin
                        r_bus_rw      <= i_rw;
                        r_bus_addr    <= i_addr;
                        r_bus_wr_data <= i_wr_data;
                        r_bus_req_    <= ENABLE_;
                        r_state       <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (w_grant) begin
                        r_bus_as_ <= ENABLE_;
                        r_state   <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    r_bus_as_ <= DISABLE_;
                    // Ready takes priority so a reply on the terminal timeout cycle completes normally.
                    if (w_ready) begin
                        if (r_bus_rw == READ) begin
                            r_rd_data <= i_bus_rd_data;
                        end
                        r_done     <= 1'b1;
                        r_bus_req_ <= DISABLE_;
                        r_state    <= ST_IDLE;
                    end else if (w_expired) begin
                        r_rd_data  <= '0;
                        r_done     <= 1'b1;
                        r_err      <= 1'b1;
                        r_bus_req_ <= DISABLE_;
                        r_state    <= ST_IDLE;
                    end
                end
                default: begin
                    r_bus_req_ <= DISABLE_;
                    r_bus_as_  <= DISABLE_;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_busy        = (r_state != ST_IDLE) || i_req;
    assign o_rd_data     = r_rd_data;
    assign o_done        = r_done;
    assign o_err         = r_err;
    assign o_bus_req_    = r_bus_req_;
    assign o_bus_as_     = r_bus_as_;
    assign o_bus_rw      = r_bus_rw;
    assign o_bus_addr    = r_bus_addr;
    assign o_bus_wr_data = r_bus_wr_data;

endmodule

// File: tb/tb_yutorina_bus_master.sv
// Directed bench for yutorina_bus_master; the timeout case runs only with YUTORINA_BUS_TIMEOUT_EN.
module tb_yutorina_bus_master;

    localparam int AW = 30;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          req;
    logic          rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] rd_data;
    logic          busy;
    logic          done;
    logic          err;
    logic          bus_req_;
    logic          bus_grnt_;
    logic          bus_as_;
    logic          bus_rw;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wr_data;
    logic [DW-1:0] bus_rd_data;
    logic          bus_rdy_;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    yutorina_bus_master #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (16)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_req         (req),
        .i_rw          (rw),
        .i_addr        (addr),
        .i_wr_data     (wr_data),
        .o_rd_data     (rd_data),
        .o_busy        (busy),
        .o_done        (done),
        .o_err         (err),
        .o_bus_req_    (bus_req_),
        .i_bus_grnt_   (bus_grnt_),
        .o_bus_as_     (bus_as_),
        .o_bus_rw      (bus_rw),
        .o_bus_addr    (bus_addr),
        .o_bus_wr_data (bus_wr_data),
        .i_bus_rd_data (bus_rd_data),
        .i_bus_rdy_    (bus_rdy_)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; rw = 1'b0; addr = '0; wr_data = '0;
        bus_grnt_ = 1'b1; bus_rdy_ = 1'b1; bus_rd_data = '0;
        tick(); tick();
        check("rst_bus_req_", bus_req_, 1);
        check("rst_bus_as_", bus_as_, 1);
        check("rst_bus_rw", bus_rw, 1);
        check("rst_bus_addr", bus_addr, 0);
        check("rst_bus_wr_data", bus_wr_data, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        tick();

        // Read, zero-wait grant, slave ready one cycle after the strobe.
        req = 1'b1; rw = 1'b1; addr = 30'h10; wr_data = 32'hFFFF_0000;
        #1;
        check("t1_busy_comb", busy, 1);
        tick();                                   // edge N
        req = 1'b0; addr = 30'h3; rw = 1'b0;      // ignored outside IDLE
        check("t1_req_low", bus_req_, 0);
        check("t1_as_idle", bus_as_, 1);
        bus_grnt_ = 1'b0;
        tick();                                   // N+1
        check("t1_as_low", bus_as_, 0);
        check("t1_addr", bus_addr, 30'h10);
        check("t1_rw", bus_rw, 1);
        tick();                                   // N+2
        check("t1_as_one_cycle", bus_as_, 1);
        check("t1_no_done_yet", done, 0);
        bus_rdy_ = 1'b0; bus_rd_data = 32'hDEAD_BEEF;
        tick();                                   // N+3
        check("t1_done", done, 1);
        check("t1_rd_data", rd_data, 32'hDEAD_BEEF);
        check("t1_req_released", bus_req_, 1);
        check("t1_err", err, 0);
        bus_rdy_ = 1'b1; bus_rd_data = 32'h0; bus_grnt_ = 1'b1;
        tick();
        check("t1_done_pulse", done, 0);
        check("t1_busy_idle", busy, 0);

        // Write 0x12345678 to 0x3FF with the grant held off three cycles.
        req = 1'b1; rw = 1'b0; addr = 30'h3FF; wr_data = 32'h1234_5678;
        tick();
        req = 1'b0; addr = 30'h2AA; wr_data = 32'h0; rw = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("t2_as_wait_grant", bus_as_, 1);
            check("t2_req_held", bus_req_, 0);
            tick();
        end
        bus_grnt_ = 1'b0;
        check("t2_as_before_grant", bus_as_, 1);
        tick();
        check("t2_as_after_grant", bus_as_, 0);
        tick();
        check("t2_as_release", bus_as_, 1);
        check("t2_addr_stable", bus_addr, 30'h3FF);
        check("t2_wdata_stable", bus_wr_data, 32'h1234_5678);
        check("t2_rw", bus_rw, 0);
        tick();                                   // slave still busy
        check("t2_no_done", done, 0);
        check("t2_addr_stable2", bus_addr, 30'h3FF);
        bus_rdy_ = 1'b0; bus_rd_data = 32'hCAFE_CAFE;
        tick();
        check("t2_done", done, 1);
        check("t2_rd_unchanged", rd_data, 32'hDEAD_BEEF);
        bus_rdy_ = 1'b1; bus_grnt_ = 1'b1;
        tick();
        check("t2_done_once", done, 0);

        // Back-to-back reads with req held across done; first ready lands on the strobe-release edge.
        req = 1'b1; rw = 1'b1; addr = 30'h20; bus_grnt_ = 1'b0;
        tick();
        check("t3_req_low", bus_req_, 0);
        tick();
        check("t3_as_low", bus_as_, 0);
        bus_rdy_ = 1'b0; bus_rd_data = 32'hA5A5_0001;
        tick();
        check("t3_done1", done, 1);
        check("t3_rd1", rd_data, 32'hA5A5_0001);
        check("t3_as_back", bus_as_, 1);
        addr = 30'h21; bus_rdy_ = 1'b1;
        tick();
        check("t3_second_start", bus_req_, 0);
        check("t3_done_cleared", done, 0);
        check("t3_addr2", bus_addr, 30'h21);
        req = 1'b0;
        tick();
        check("t3_as2_low", bus_as_, 0);
        bus_rdy_ = 1'b0; bus_rd_data = 32'h0BAD_F00D;
        tick();
        check("t3_done2", done, 1);
        check("t3_rd2", rd_data, 32'h0BAD_F00D);
        bus_rdy_ = 1'b1; bus_grnt_ = 1'b1;
        tick();
        check("t3_done2_pulse", done, 0);

        // Reset while in ACCESS releases the bus with no completion.
        req = 1'b1; rw = 1'b1; addr = 30'h30; bus_grnt_ = 1'b0;
        tick();
        req = 1'b0;
        tick();
        check("t4_in_access", bus_as_, 0);
        rst = 1'b1;
        tick();
        check("t4_req_rel", bus_req_, 1);
        check("t4_as_rel", bus_as_, 1);
        check("t4_no_done", done, 0);
        check("t4_rd_cleared", rd_data, 0);
        rst = 1'b0; bus_rdy_ = 1'b0; bus_rd_data = 32'h7777_7777;
        tick();
        check("t4_late_rdy_ignored", done, 0);
        check("t4_idle_busy", busy, 0);
        bus_rdy_ = 1'b1; bus_grnt_ = 1'b1;
        tick();

        // Spurious ready while waiting for the grant.
        bus_rdy_ = 1'b0; bus_rd_data = 32'h9999_9999;
        req = 1'b1; rw = 1'b1; addr = 30'h40;
        tick();
        req = 1'b0;
        tick();
        check("t5_spur_done1", done, 0);
        check("t5_spur_as", bus_as_, 1);
        tick();
        check("t5_spur_done2", done, 0);
        bus_rdy_ = 1'b1; bus_grnt_ = 1'b0;
        tick();
        check("t5_as_low", bus_as_, 0);
        check("t5_no_done", done, 0);
        tick();
        check("t5_wait", done, 0);
        bus_rdy_ = 1'b0; bus_rd_data = 32'h1111_2222;
        tick();
        check("t5_done", done, 1);
        check("t5_rd", rd_data, 32'h1111_2222);
        check("t5_err", err, 0);
        bus_rdy_ = 1'b1; bus_grnt_ = 1'b1;
        tick();

`ifdef YUTORINA_BUS_TIMEOUT_EN
        // Slave never ready: abort on the 16th ACCESS edge.
        req = 1'b1; rw = 1'b1; addr = 30'h50; bus_grnt_ = 1'b0;
        tick();
        req = 1'b0;
        tick();                                   // entered ACCESS
        for (int i = 0; i < 15; i++) begin
            tick();
            check("t6_no_early_abort", done, 0);
        end
        tick();
        check("t6_done", done, 1);
        check("t6_err", err, 1);
        check("t6_rd_zero", rd_data, 0);
        check("t6_bus_rel", bus_req_, 1);
        tick();
        check("t6_err_pulse", err, 0);

        // Ready on the terminal cycle wins.
        req = 1'b1; rw = 1'b1; addr = 30'h51;
        tick();
        req = 1'b0;
        tick();
        for (int i = 0; i < 15; i++) tick();
        bus_rdy_ = 1'b0; bus_rd_data = 32'h5555_AAAA;
        tick();
        check("t7_done", done, 1);
        check("t7_no_err", err, 0);
        check("t7_rd", rd_data, 32'h5555_AAAA);
        bus_rdy_ = 1'b1; bus_grnt_ = 1'b1;
        tick();
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
